// File: rtl/lms_pkg.sv
// Shared constants, FSM state type and saturating narrow for the LMS weight-update datapath.
package lms_pkg;

    localparam int W      = 10;
    localparam int NTAPS  = 8;
    localparam int PROD_W = 2 * W;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } lms_state_e;

    // Clamp a wide unsigned value to W bits, saturating at all-ones.
    function automatic logic [W-1:0] sat_narrow(input logic [PROD_W-1:0] v);
        return (|v[PROD_W-1:W]) ? {W{1'b1}} : v[W-1:0];
    endfunction

endpackage

// File: rtl/lms_tap_line.sv
// Eight-deep sample delay line with shift enable, synchronous clear and indexed read.
module lms_tap_line
    import lms_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [W-1:0]     din,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [W-1:0]     rd_data
);

    logic [W-1:0] taps [NTAPS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
        end else if (shift_en) begin
            taps[0] <= din;
            for (int i = 1; i < NTAPS; i++) taps[i] <= taps[i-1];
        end
    end

    assign rd_data = taps[rd_idx];

endmodule

// File: rtl/lms_update_gen.sv
// LMS weight-correction generator: A_k = (|e| * x_k) >> MU_SHIFT, one tap per cycle.
// Define LMS_ROUND_EN for round-half-up before the shift; otherwise the shift truncates.
module lms_update_gen
    import lms_pkg::*;
#(
    parameter int MU_SHIFT = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [9:0]   x_in,
    input  logic [9:0]   e_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [9:0]   A1,
    output logic [9:0]   A2,
    output logic [9:0]   A3,
    output logic [9:0]   A4,
    output logic [9:0]   A5,
    output logic [9:0]   A6,
    output logic [9:0]   A7,
    output logic [9:0]   A8,
    output logic         sg,
    output logic [1:0]   state_dbg
);

    // Handshake: a pair is taken on a rising edge with in_valid && in_ready; a result
    // is taken on a rising edge with out_valid && out_ready. Neither side may drop
    // data it has offered, and ready on either side is ignored while valid is low.

    lms_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     mag_q;
    logic             sg_q;
    logic [W-1:0]     a_q [NTAPS];

    logic             accept;
    logic [W-1:0]     tap_rd;
    logic [W-1:0]     mag_d;
    logic [PROD_W-1:0] product, biased, shifted;
    logic [W-1:0]     a_next;

`ifdef LMS_ROUND_EN
    localparam int RND_POS = (MU_SHIFT > 0) ? MU_SHIFT - 1 : 0;
    localparam logic [PROD_W-1:0] ROUND_BIAS =
        (MU_SHIFT > 0) ? (PROD_W'(1) << RND_POS) : '0;
`else
    localparam logic [PROD_W-1:0] ROUND_BIAS = '0;
`endif

    assign accept = (state_q == IDLE) && in_valid;

    // -512 maps to 512, which still fits the unsigned W-bit magnitude.
    assign mag_d = e_in[W-1] ? (~e_in + W'(1)) : e_in;

    lms_tap_line u_tap_line (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .din      (x_in),
        .rd_idx   (idx_q),
        .rd_data  (tap_rd)
    );

    assign product = PROD_W'(mag_q) * PROD_W'(tap_rd);
    assign biased  = product + ROUND_BIAS;
    assign shifted = biased >> MU_SHIFT;
    assign a_next  = sat_narrow(shifted);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (idx_q == IDX_W'(NTAPS - 1)) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mag_q   <= '0;
            sg_q    <= 1'b0;
            for (int i = 0; i < NTAPS; i++) a_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mag_q <= mag_d;
                sg_q  <= e_in[W-1];
                idx_q <= '0;
            end
            if (state_q == CALC) begin
                a_q[idx_q] <= a_next;
                idx_q      <= idx_q + IDX_W'(1);
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign sg        = sg_q;
    assign state_dbg = state_q;

    assign A1 = a_q[0];
    assign A2 = a_q[1];
    assign A3 = a_q[2];
    assign A4 = a_q[3];
    assign A5 = a_q[4];
    assign A6 = a_q[5];
    assign A7 = a_q[6];
    assign A8 = a_q[7];

endmodule

// File: tb/tb_lms_update_gen.sv
// Self-checking bench for lms_update_gen; build with +define+LMS_ROUND_EN for the rounding variant.
module tb_lms_update_gen;
    import lms_pkg::*;

    localparam int MU    = 10;
    localparam int EXP_W = 1 + NTAPS * W;
`ifdef LMS_ROUND_EN
    localparam logic [9:0] ROUND_A1 = 10'd1;
`else
    localparam logic [9:0] ROUND_A1 = 10'd0;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ready, out_valid, out_ready, sg;
    logic [9:0] x_in, e_in, a1, a2, a3, a4, a5, a6, a7, a8;
    logic [1:0] state_dbg;
    logic [9:0] a_obs [8];

    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_sg;
    logic [9:0] s_x, s_e, s_a1, s_a2, s_a3, s_a4, s_a5, s_a6, s_a7, s_a8;
    logic [1:0] s_state_dbg;

    always_comb begin
        a_obs[0] = a1; a_obs[1] = a2; a_obs[2] = a3; a_obs[3] = a4;
        a_obs[4] = a5; a_obs[5] = a6; a_obs[6] = a7; a_obs[7] = a8;
    end

    lms_update_gen #(.MU_SHIFT(MU)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .e_in(e_in), .out_valid(out_valid), .out_ready(out_ready),
        .A1(a1), .A2(a2), .A3(a3), .A4(a4), .A5(a5), .A6(a6), .A7(a7), .A8(a8),
        .sg(sg), .state_dbg(state_dbg)
    );

    lms_update_gen #(.MU_SHIFT(0)) u_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .x_in(s_x), .e_in(s_e), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .A1(s_a1), .A2(s_a2), .A3(s_a3), .A4(s_a4), .A5(s_a5), .A6(s_a6), .A7(s_a7), .A8(s_a8),
        .sg(s_sg), .state_dbg(s_state_dbg)
    );

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q [$];
    logic [9:0]       m_taps [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] mag_of(input logic [9:0] e);
        int v;
        v = $signed(e);
        if (v < 0) v = -v;
        return v[9:0];
    endfunction

    function automatic logic [9:0] model_a(input logic [9:0] x, input logic [9:0] mag, input int mu);
        longint p;
        p = longint'(x) * longint'(mag);
`ifdef LMS_ROUND_EN
        if (mu > 0) p = p + (longint'(1) << (mu - 1));
`endif
        p = p >> mu;
        return (p > 1023) ? 10'd1023 : p[9:0];
    endfunction

    // driver tasks
    task automatic send(input logic [9:0] x, input logic [9:0] e);
        int n;
        logic [EXP_W-1:0] ex;
        logic [9:0] mg;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        in_valid = 1'b1;
        x_in = x;
        e_in = e;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 7; k > 0; k--) m_taps[k] = m_taps[k-1];
        m_taps[0] = x;
        mg = mag_of(e);
        ex[EXP_W-1] = e[9];
        for (int k = 0; k < 8; k++) ex[(7-k)*W +: W] = model_a(m_taps[k], mg, MU);
        exp_q.push_back(ex);
    endtask

    task automatic collect(input int hold);
        int lat;
        logic [EXP_W-1:0] ex;
        logic [9:0] snap [8];
        logic snap_sg;
        logic stable;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        if (!out_valid) begin
            check("collect_timeout", 0, 1);
            return;
        end
        check("latency", lat, 9);
        for (int k = 0; k < 8; k++) snap[k] = a_obs[k];
        snap_sg = sg;
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0];
            x_in = 10'($urandom_range(0, 1023));
            e_in = 10'($urandom_range(0, 1023));
            @(negedge clk);
            stable = (sg === snap_sg);
            for (int k = 0; k < 8; k++) if (a_obs[k] !== snap[k]) stable = 1'b0;
            check("hold_stable", stable, 1);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        if (exp_q.size() == 0) begin
            check("queue_empty", 0, 1);
        end else begin
            ex = exp_q.pop_front();
            check("sg", sg, ex[EXP_W-1]);
            for (int k = 0; k < 8; k++) check($sformatf("A%0d", k + 1), a_obs[k], ex[(7-k)*W +: W]);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("xfer_out_valid", out_valid, 0);
        check("xfer_in_ready", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; e_in = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_x = '0; s_e = '0;
        for (int k = 0; k < 8; k++) m_taps[k] = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sg", sg, 0);
        check("rst_state", state_dbg, IDLE);
        for (int k = 0; k < 8; k++) check($sformatf("rst_A%0d", k + 1), a_obs[k], 0);
        rst = 1'b0;

        // +512 is not representable in 10-bit two's complement; 10'h200 carries |e|=512.
        send(10'd1023, 10'h200);
        collect(0);

        for (int i = 1; i <= 8; i++) begin
            send(10'(i * 100), 10'd0);
            collect(0);
        end
        send(10'd900, 10'h300);
        collect(0);
        check("neg_sg", sg, 1);
        check("neg_A1", a1, 225);
        check("neg_A8", a8, 50);

        send(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
        collect(20);

        // abort mid-computation
        send(10'd500, 10'h39c);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_sg", sg, 0);
        check("abort_state", state_dbg, IDLE);
        for (int k = 0; k < 8; k++) check($sformatf("abort_A%0d", k + 1), a_obs[k], 0);
        rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 8; k++) m_taps[k] = '0;
        send(10'd1023, 10'h200);
        collect(0);

        repeat (6) begin
            send(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
            collect(int'($urandom_range(0, 3)));
        end

        send(10'd3, 10'd171);
        collect(0);
        check("round_A1", a1, ROUND_A1);

        // saturation on the unshifted instance
        @(negedge clk);
        s_in_valid = 1'b1; s_x = 10'd1023; s_e = 10'd2;
        @(posedge clk);
        #1 s_in_valid = 1'b0;
        n = 0;
        while (!s_out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("sat_out_valid", s_out_valid, 1);
        check("sat_A1", s_a1, model_a(10'd1023, 10'd2, 0));
        check("sat_A1_const", s_a1, 1023);
        check("sat_A2", s_a2, 0);
        check("sat_sg", s_sg, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
